// File: rtl/lut_arbiter.sv
// rtl/lut_arbiter.sv - round-robin shared key/data lookup table with registered response
module lut_arbiter #(
    parameter int NR_REQ      = 4,
    parameter int NR_KEY      = 8,
    parameter int KEY_LEN     = 7,
    parameter int DATA_LEN    = 32,
    parameter bit HAS_DEFAULT = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cfg_we,
    input  logic                        cfg_clr,
    input  logic [$clog2(NR_KEY)-1:0]   cfg_idx,
    input  logic [KEY_LEN-1:0]          cfg_key,
    input  logic [DATA_LEN-1:0]         cfg_data,
    input  logic [DATA_LEN-1:0]         default_out,
    input  logic [NR_REQ-1:0]           req_valid,
    input  logic [NR_REQ*KEY_LEN-1:0]   req_key,
    output logic [NR_REQ-1:0]           req_ready,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [$clog2(NR_REQ)-1:0]   rsp_id,
    output logic [DATA_LEN-1:0]         rsp_data,
    output logic                        rsp_hit
);

    localparam int IDX_W = $clog2(NR_KEY);
    localparam int ID_W  = $clog2(NR_REQ);

    typedef enum logic {IDLE, FULL} state_t;

    state_t                 state;
    state_t                 state_nx;

    logic [NR_KEY-1:0]      ent_valid;
    logic [KEY_LEN-1:0]     ent_key  [NR_KEY];
    logic [DATA_LEN-1:0]    ent_data [NR_KEY];

    logic [ID_W-1:0]        last_grant;
    logic [ID_W-1:0]        win_id;
    logic                   win_found;
    logic                   can_accept;
    logic                   handshake;
    int                     cand;
    logic [KEY_LEN-1:0]     win_key;
    logic                   lk_hit;
    logic [DATA_LEN-1:0]    lk_data;

    // A write in the same cycle as a clear survives the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_valid <= '0;
        end else begin
            for (int k = 0; k < NR_KEY; k++) begin
                if (cfg_we && cfg_idx == IDX_W'(k)) begin
                    ent_valid[k] <= 1'b1;
                end else if (cfg_clr) begin
                    ent_valid[k] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NR_KEY; k++) begin
            if (cfg_we && cfg_idx == IDX_W'(k)) begin
                ent_key[k]  <= cfg_key;
                ent_data[k] <= cfg_data;
            end
        end
    end

    assign can_accept = rst_n && !cfg_we && !cfg_clr && (!rsp_valid || rsp_ready);

    always_comb begin
        win_id    = '0;
        win_found = 1'b0;
        cand      = 0;
        for (int i = 1; i <= NR_REQ; i++) begin
            cand = (int'(last_grant) + i) % NR_REQ;
            if (!win_found && req_valid[ID_W'(cand)]) begin
                win_found = 1'b1;
                win_id    = ID_W'(cand);
            end
        end
    end

    assign handshake = can_accept && win_found;
    assign req_ready = handshake ? (NR_REQ'(1) << win_id) : '0;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        win_key = '0;
        for (int n = 0; n < NR_REQ; n++) begin
            if (win_id == ID_W'(n)) begin
                win_key = req_key[n*KEY_LEN +: KEY_LEN];
            end
        end
        lk_hit  = 1'b0;
        lk_data = HAS_DEFAULT ? default_out : '0;
        for (int k = NR_KEY - 1; k >= 0; k--) begin
            if (ent_valid[k] && ent_key[k] == win_key) begin
                lk_hit  = 1'b1;
                lk_data = ent_data[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (handshake) state_nx = FULL;
            FULL: begin
                if (handshake)      state_nx = FULL;
                else if (rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign rsp_valid = (state == FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= ID_W'(NR_REQ - 1);
            rsp_id     <= '0;
            rsp_data   <= '0;
            rsp_hit    <= 1'b0;
        end else if (handshake) begin
            last_grant <= win_id;
            rsp_id     <= win_id;
            rsp_data   <= lk_data;
            rsp_hit    <= lk_hit;
        end
    end

endmodule

// File: tb/tb_lut_arbiter.sv
// tb/tb_lut_arbiter.sv - directed vector bench for lut_arbiter
module tb_lut_arbiter;

    localparam logic [31:0] DEF = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic        cfg_clr = 1'b0;
    logic [2:0]  cfg_idx = '0;
    logic [6:0]  cfg_key = '0;
    logic [31:0] cfg_data = '0;
    logic [31:0] default_out = DEF;
    logic [3:0]  req_valid = '0;
    logic [27:0] req_key = '0;
    logic        rsp_ready = 1'b0;

    logic [3:0]  req_ready, req_ready0;
    logic        rsp_valid, rsp_valid0;
    logic [1:0]  rsp_id, rsp_id0;
    logic [31:0] rsp_data, rsp_data0;
    logic        rsp_hit, rsp_hit0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    lut_arbiter #(.NR_REQ(4), .NR_KEY(8), .KEY_LEN(7), .DATA_LEN(32), .HAS_DEFAULT(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_clr(cfg_clr), .cfg_idx(cfg_idx),
        .cfg_key(cfg_key), .cfg_data(cfg_data), .default_out(default_out),
        .req_valid(req_valid), .req_key(req_key), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_hit(rsp_hit)
    );

    lut_arbiter #(.NR_REQ(4), .NR_KEY(8), .KEY_LEN(7), .DATA_LEN(32), .HAS_DEFAULT(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_clr(cfg_clr), .cfg_idx(cfg_idx),
        .cfg_key(cfg_key), .cfg_data(cfg_data), .default_out(default_out),
        .req_valid(req_valid), .req_key(req_key), .req_ready(req_ready0),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready), .rsp_id(rsp_id0),
        .rsp_data(rsp_data0), .rsp_hit(rsp_hit0)
    );

    typedef struct {
        logic        we;
        logic        clr;
        logic [2:0]  idx;
        logic [6:0]  key;
        logic [31:0] data;
        logic [3:0]  rv;
        logic [27:0] rk;
        logic [3:0]  e_ready;
        logic        e_valid;
        logic [1:0]  e_id;
        logic [31:0] e_data;
        logic [31:0] e_data0;
        logic        e_hit;
    } vec_t;

    vec_t vt[12];

    function automatic logic [27:0] keys(input logic [6:0] k0, input logic [6:0] k1,
                                         input logic [6:0] k2, input logic [6:0] k3);
        return {k3, k2, k1, k0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        vt[0]  = '{1'b1, 1'b0, 3'd0, 7'h33, 32'h13, 4'b0010, keys(7'h00, 7'h33, 7'h00, 7'h00),
                   4'b0000, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0};
        vt[1]  = '{1'b0, 1'b0, 3'd0, 7'h00, 32'h0, 4'b0010, keys(7'h00, 7'h33, 7'h00, 7'h00),
                   4'b0010, 1'b1, 2'd1, 32'h13, 32'h13, 1'b1};
        vt[2]  = '{1'b0, 1'b0, 3'd0, 7'h00, 32'h0, 4'b0001, keys(7'h7F, 7'h33, 7'h00, 7'h00),
                   4'b0001, 1'b1, 2'd0, DEF, 32'h0, 1'b0};
        vt[3]  = '{1'b1, 1'b0, 3'd2, 7'h13, 32'hA, 4'b0000, keys(7'h00, 7'h00, 7'h00, 7'h00),
                   4'b0000, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0};
        vt[4]  = '{1'b1, 1'b0, 3'd5, 7'h13, 32'hB, 4'b0000, keys(7'h00, 7'h00, 7'h00, 7'h00),
                   4'b0000, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0};
        vt[5]  = '{1'b0, 1'b0, 3'd0, 7'h00, 32'h0, 4'b1000, keys(7'h00, 7'h00, 7'h00, 7'h13),
                   4'b1000, 1'b1, 2'd3, 32'hA, 32'hA, 1'b1};
        vt[6]  = '{1'b1, 1'b0, 3'd2, 7'h13, 32'hC, 4'b0100, keys(7'h00, 7'h00, 7'h13, 7'h00),
                   4'b0000, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0};
        vt[7]  = '{1'b0, 1'b0, 3'd0, 7'h00, 32'h0, 4'b0100, keys(7'h00, 7'h00, 7'h13, 7'h00),
                   4'b0100, 1'b1, 2'd2, 32'hC, 32'hC, 1'b1};
        vt[8]  = '{1'b0, 1'b1, 3'd0, 7'h00, 32'h0, 4'b0001, keys(7'h33, 7'h00, 7'h00, 7'h00),
                   4'b0000, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0};
        vt[9]  = '{1'b0, 1'b0, 3'd0, 7'h00, 32'h0, 4'b0001, keys(7'h33, 7'h00, 7'h00, 7'h00),
                   4'b0001, 1'b1, 2'd0, DEF, 32'h0, 1'b0};
        vt[10] = '{1'b1, 1'b1, 3'd4, 7'h55, 32'h44, 4'b0000, keys(7'h00, 7'h00, 7'h00, 7'h00),
                   4'b0000, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0};
        vt[11] = '{1'b0, 1'b0, 3'd0, 7'h00, 32'h0, 4'b0011, keys(7'h33, 7'h55, 7'h00, 7'h00),
                   4'b0010, 1'b1, 2'd1, 32'h44, 32'h44, 1'b1};

        // reset state, with requests pending
        req_valid = 4'hF;
        #12;
        chk("reset_ready", 32'(req_ready), 32'h0);
        chk("reset_valid", 32'(rsp_valid), 32'h0);
        chk("reset_id", 32'(rsp_id), 32'h0);
        chk("reset_data", rsp_data, 32'h0);
        chk("reset_hit", 32'(rsp_hit), 32'h0);
        req_valid = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            cfg_we = vt[i].we;
            cfg_clr = vt[i].clr;
            cfg_idx = vt[i].idx;
            cfg_key = vt[i].key;
            cfg_data = vt[i].data;
            req_valid = vt[i].rv;
            req_key = vt[i].rk;
            rsp_ready = 1'b1;
            #1;
            chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'(vt[i].e_ready));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid", i), 32'(rsp_valid), 32'(vt[i].e_valid));
            if (vt[i].e_valid) begin
                chk($sformatf("v%0d_id", i), 32'(rsp_id), 32'(vt[i].e_id));
                chk($sformatf("v%0d_data", i), rsp_data, vt[i].e_data);
                chk($sformatf("v%0d_data_nodef", i), rsp_data0, vt[i].e_data0);
                chk($sformatf("v%0d_hit", i), 32'(rsp_hit), 32'(vt[i].e_hit));
            end
        end

        // reset while a response is pending
        @(negedge clk);
        cfg_we = 1'b0;
        cfg_clr = 1'b0;
        req_valid = 4'h0;
        rsp_ready = 1'b0;
        chk("pre_rst_valid", 32'(rsp_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(rsp_valid), 32'h0);
        chk("mid_rst_ready", 32'(req_ready), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // round robin from reset; entry 4 (key 0x55) must be gone
        req_valid = 4'hF;
        req_key = keys(7'h55, 7'h55, 7'h55, 7'h55);
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            chk($sformatf("rr%0d_ready", i), 32'(req_ready), 32'(4'b0001 << (i % 4)));
            @(posedge clk);
            #1;
            chk($sformatf("rr%0d_id", i), 32'(rsp_id), 32'(i % 4));
            chk($sformatf("rr%0d_valid", i), 32'(rsp_valid), 32'h1);
            chk($sformatf("rr%0d_hit", i), 32'(rsp_hit), 32'h0);
            chk($sformatf("rr%0d_data", i), rsp_data, DEF);
        end

        // consumer stalls for 3 cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rsp_ready = 1'b0;
            req_key = keys(7'(i), 7'(i), 7'(i), 7'(i));
            #1;
            chk($sformatf("stall%0d_ready", i), 32'(req_ready), 32'h0);
            @(posedge clk);
            #1;
            chk($sformatf("stall%0d_valid", i), 32'(rsp_valid), 32'h1);
            chk($sformatf("stall%0d_id", i), 32'(rsp_id), 32'h0);
            chk($sformatf("stall%0d_data", i), rsp_data, DEF);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        chk("unstall_ready", 32'(req_ready), 32'h2);
        @(posedge clk);
        #1;
        chk("unstall_id", 32'(rsp_id), 32'h1);
        chk("unstall_valid", 32'(rsp_valid), 32'h1);

        @(negedge clk);
        req_valid = 4'h0;
        @(posedge clk);
        #1;
        chk("drain_valid", 32'(rsp_valid), 32'h0);
        chk("drain_hold_id", 32'(rsp_id), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
